// File: rtl/dl_spi_ctrl_if.sv
// SPI pin bundle between the board controller (master) and the delay-line
// control slave.
interface dl_spi_ctrl_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/dl_spi_ctrl.sv
// Delay-line control slave: SPI frames write per-channel shadow tap codes,
// which are committed to the active taps by command, ext_load or auto mode.
module dl_spi_ctrl #(
  parameter int NCH     = 4,
  parameter int TAPW    = 7,
  parameter int TAP_RST = 0
) (
  input  logic                clk,
  input  logic                rst,
  dl_spi_ctrl_if.slave        spi,
  input  logic                ext_load,
  output logic [NCH*TAPW-1:0] dl_tap,
  output logic                dl_load,
  output logic                pending
);
  localparam logic [TAPW-1:0] TAP_RST_V = TAPW'(TAP_RST);

  logic [1:0]      r_sck_sync, r_cs_sync, r_mosi_sync;
  logic            r_sck_prev;
  logic [3:0]      r_bit_cnt;
  logic [14:0]     r_shift;
  logic [15:0]     r_frame;
  logic            r_frame_vld;
  logic [7:0]      r_tx;
  logic [3:0]      r_rd_bits;
  logic            r_rd_act;
  logic            r_miso, r_miso_oe;
  logic [TAPW-1:0] r_shadow [NCH];
  logic [NCH*TAPW-1:0] r_tap;
  logic            r_load, r_pending, r_auto, r_commit_req, r_auto_vld;
  logic [6:0]      r_auto_ch;

  logic            w_cs_act, w_sck, w_rise, w_fall;
  logic [15:0]     w_word;
  logic [7:0]      w_rd_data;
  logic            w_wr;
  logic [6:0]      w_addr;
  logic [7:0]      w_data;
  logic            w_unused_data;

  assign w_cs_act = ~r_cs_sync[1];
  assign w_sck    = r_sck_sync[1];
  assign w_rise   = w_cs_act & w_sck & ~r_sck_prev;
  assign w_fall   = w_cs_act & ~w_sck & r_sck_prev;
  assign w_word   = {r_shift, r_mosi_sync[1]};

  assign w_wr     = r_frame_vld & ~r_frame[15];
  assign w_addr   = r_frame[14:8];
  assign w_data   = r_frame[7:0];
  assign w_unused_data = ^w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], spi.spi_sck};
      r_cs_sync   <= {r_cs_sync[0], spi.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], spi.spi_mosi};
      r_sck_prev  <= r_sck_sync[1];
    end
  end

  // Header byte is complete on the 8th rising edge: w_word[7:0] is it.
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (w_word[6:0] == 7'(i)) w_rd_data = 8'(r_shadow[i]);
    end
    if (w_word[6:0] == 7'h40) w_rd_data = {6'b0, r_auto, 1'b0};
    if (w_word[6:0] == 7'h41) w_rd_data = {7'b0, r_pending};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= '0;
      r_frame     <= '0;
      r_frame_vld <= 1'b0;
      r_tx        <= 8'h00;
      r_rd_bits   <= 4'd0;
      r_rd_act    <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
    end else begin
      r_frame_vld <= 1'b0;
      r_miso_oe   <= w_cs_act;
      if (!w_cs_act) begin
        r_bit_cnt <= 4'd0;
        r_rd_act  <= 1'b0;
        r_miso    <= 1'b0;
      end else begin
        if (w_rise) begin
          r_shift   <= w_word[14:0];
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) begin
            r_frame     <= w_word;
            r_frame_vld <= 1'b1;
          end
          if (r_bit_cnt == 4'd7 && w_word[7]) begin
            r_tx      <= w_rd_data;
            r_rd_act  <= 1'b1;
            r_rd_bits <= 4'd0;
          end
        end
        if (w_fall && r_rd_act) begin
          if (r_rd_bits == 4'd8) begin
            r_miso   <= 1'b0;
            r_rd_act <= 1'b0;
          end else begin
            r_miso    <= r_tx[7];
            r_tx      <= {r_tx[6:0], 1'b0};
            r_rd_bits <= r_rd_bits + 4'd1;
          end
        end
      end
    end
  end

  // Commit reads shadows before this edge's write, so a same-cycle write stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_shadow[i] <= TAP_RST_V;
      r_tap        <= {NCH{TAP_RST_V}};
      r_load       <= 1'b0;
      r_pending    <= 1'b0;
      r_auto       <= 1'b0;
      r_commit_req <= 1'b0;
      r_auto_vld   <= 1'b0;
      r_auto_ch    <= 7'd0;
    end else begin
      r_load       <= 1'b0;
      r_commit_req <= 1'b0;
      r_auto_vld   <= 1'b0;
      if (r_commit_req || ext_load) begin
        for (int i = 0; i < NCH; i++) r_tap[i*TAPW +: TAPW] <= r_shadow[i];
        r_load    <= 1'b1;
        r_pending <= 1'b0;
      end else if (r_auto_vld) begin
        for (int i = 0; i < NCH; i++) begin
          if (r_auto_ch == 7'(i)) r_tap[i*TAPW +: TAPW] <= r_shadow[i];
        end
        r_load <= 1'b1;
      end
      if (w_wr) begin
        for (int i = 0; i < NCH; i++) begin
          if (w_addr == 7'(i)) begin
            r_shadow[i] <= w_data[TAPW-1:0];
            if (r_auto) begin
              r_auto_vld <= 1'b1;
              r_auto_ch  <= w_addr;
            end else begin
              r_pending <= 1'b1;
            end
          end
        end
        if (w_addr == 7'h40) begin
          r_auto       <= w_data[1];
          r_commit_req <= w_data[0];
        end
      end
    end
  end

  assign dl_tap          = r_tap;
  assign dl_load         = r_load;
  assign pending         = r_pending;
  assign spi.spi_miso    = r_miso;
  assign spi.spi_miso_oe = r_miso_oe;
endmodule
